// File: rtl/mac_result_drain.sv
// Result drain for the MAC array: counts last-stage enables, snapshots the accumulators,
// streams them lane 0 first over valid/ready, then pulses the array clear.
// Optional res_par output (XOR of res_data) when MAC_DRAIN_PARITY_EN is defined.
module mac_result_drain #(
   parameter int unsigned N_MAC = 8,
   parameter int unsigned C_W   = 24,
   parameter int unsigned K_LEN = 8,
   localparam int unsigned IDX_W = (N_MAC > 1) ? $clog2(N_MAC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             en_last,
   input  logic [C_W-1:0]   c_in [0:N_MAC-1],
   output logic [C_W-1:0]   res_data,
   output logic [IDX_W-1:0] res_idx,
   output logic             res_valid,
   output logic             res_last,
   input  logic             res_ready,
   output logic             mac_clr,
   output logic             busy,
   output logic             done
`ifdef MAC_DRAIN_PARITY_EN
   ,
   output logic             res_par
`endif
);

   localparam int unsigned CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MAC - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

   typedef enum logic [2:0] {IDLE, COUNT, SETTLE, DRAIN, CLEAR} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [C_W-1:0]   shadow [0:N_MAC-1];

   assign idx_nxt = idx + IDX_W'(1);

   // Pass sequencer; every output is loaded on the edge that enters the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         for (int i = 0; i < int'(N_MAC); i++) shadow[i] <= '0;
         res_data  <= '0;
         res_idx   <= '0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
         mac_clr   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef MAC_DRAIN_PARITY_EN
         res_par   <= 1'b0;
`endif
      end else begin
         mac_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= COUNT;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            COUNT: begin
               if (en_last) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) state <= SETTLE;
               end
            end
            SETTLE: begin
               // The final accumulate has landed in c_in by now; freeze it.
               shadow    <= c_in;
               idx       <= '0;
               res_data  <= c_in[0];
               res_idx   <= '0;
               res_valid <= 1'b1;
               res_last  <= (IDX_LAST == '0);
`ifdef MAC_DRAIN_PARITY_EN
               res_par   <= ^c_in[0];
`endif
               state     <= DRAIN;
            end
            DRAIN: begin
               if (res_ready) begin
                  if (idx == IDX_LAST) begin
                     state     <= CLEAR;
                     res_data  <= '0;
                     res_idx   <= '0;
                     res_valid <= 1'b0;
                     res_last  <= 1'b0;
                     mac_clr   <= 1'b1;
                     done      <= 1'b1;
`ifdef MAC_DRAIN_PARITY_EN
                     res_par   <= 1'b0;
`endif
                  end else begin
                     idx      <= idx_nxt;
                     res_data <= shadow[idx_nxt];
                     res_idx  <= idx_nxt;
                     res_last <= (idx_nxt == IDX_LAST);
`ifdef MAC_DRAIN_PARITY_EN
                     res_par  <= ^shadow[idx_nxt];
`endif
                  end
               end
            end
            CLEAR: begin
               state <= IDLE;
               idx   <= '0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
